// File: rtl/vm_port_arbiter_if.sv
// Vm port bundle: work pipeline, configurator and single-port Vm SRAM signals.
// The slave modport is the arbiter's view; the master modport is its environment.
interface vm_port_arbiter_if #(
  parameter int unsigned NNW = 12,
  parameter int unsigned VW  = 20
) ();

  logic           wk_re;
  logic           wk_we;
  logic [NNW-1:0] wk_addr;
  logic [VW-1:0]  wk_wdata;
  logic           wk_ready;
  logic           wk_rvld;
  logic [VW-1:0]  wk_rdata;

  logic           cfg_re;
  logic           cfg_we;
  logic [NNW-1:0] cfg_addr;
  logic [VW-1:0]  cfg_wdata;
  logic           cfg_busy;
  logic           cfg_rvld;
  logic [VW-1:0]  cfg_rdata;

  logic           mem_re;
  logic           mem_we;
  logic [NNW-1:0] mem_addr;
  logic [VW-1:0]  mem_wdata;
  logic [VW-1:0]  mem_rdata;

  modport slave (
    input  wk_re, wk_we, wk_addr, wk_wdata,
    output wk_ready, wk_rvld, wk_rdata,
    input  cfg_re, cfg_we, cfg_addr, cfg_wdata,
    output cfg_busy, cfg_rvld, cfg_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output wk_re, wk_we, wk_addr, wk_wdata,
    input  wk_ready, wk_rvld, wk_rdata,
    output cfg_re, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_busy, cfg_rvld, cfg_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/vm_port_arbiter.sv
// Shares the single-port Vm SRAM between the work pipeline (zero-latency priority)
// and a one-deep configurator slot that is forced through after STARVE_MAX work cycles.
module vm_port_arbiter #(
  parameter int unsigned NNW        = 12,
  parameter int unsigned VW         = 20,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic               clk,
  input logic               rst_n,
  vm_port_arbiter_if.slave  bus
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] StarveLimit = SW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StPend, StGrant} state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  starve_q, starve_d;

  logic           slot_we_q;
  logic [NNW-1:0] slot_addr_q;
  logic [VW-1:0]  slot_wdata_q;

  logic           rd_pend_q;
  logic           rd_owner_q;
  logic [VW-1:0]  wk_rdata_q, cfg_rdata_q;

  logic           wk_req, cfg_pulse, capture;
  logic           mem_re, mem_we;
  logic [NNW-1:0] mem_addr;
  logic [VW-1:0]  mem_wdata;
  logic           wk_rvld, cfg_rvld;

  assign wk_req    = bus.wk_re | bus.wk_we;
  assign cfg_pulse = bus.cfg_re | bus.cfg_we;
  // The slot only accepts pulses while empty, i.e. while cfg_busy is low.
  assign capture   = (state_q == StIdle) && cfg_pulse;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_pulse) begin
          state_d  = StPend;
          starve_d = '0;
        end
      end
      StPend: begin
        if (wk_req && (starve_q != StarveLimit)) begin
          starve_d = starve_q + SW'(1);
        end
        if (!wk_req || (starve_d == StarveLimit)) begin
          state_d = StGrant;
        end
      end
      StGrant: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = bus.wk_addr;
    mem_wdata = bus.wk_wdata;
    if (state_q == StGrant) begin
      mem_we    = slot_we_q;
      mem_re    = ~slot_we_q;
      mem_addr  = slot_addr_q;
      mem_wdata = slot_wdata_q;
    end else if (bus.wk_we) begin
      // Simultaneous re/we from the work side is resolved as a write.
      mem_we = 1'b1;
    end else if (bus.wk_re) begin
      mem_re = 1'b1;
    end
  end

  assign wk_rvld  = rd_pend_q & ~rd_owner_q;
  assign cfg_rvld = rd_pend_q & rd_owner_q;

  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.wk_ready  = (state_q != StGrant);
  assign bus.cfg_busy  = (state_q != StIdle);
  assign bus.wk_rvld   = wk_rvld;
  assign bus.cfg_rvld  = cfg_rvld;
  assign bus.wk_rdata  = wk_rvld  ? bus.mem_rdata : wk_rdata_q;
  assign bus.cfg_rdata = cfg_rvld ? bus.mem_rdata : cfg_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_we_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
    end else if (capture) begin
      slot_we_q    <= bus.cfg_we;
      slot_addr_q  <= bus.cfg_addr;
      slot_wdata_q <= bus.cfg_wdata;
    end
  end

  // Owner tag travels with the read so the returning data lands on the right side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      wk_rdata_q  <= '0;
      cfg_rdata_q <= '0;
    end else begin
      rd_pend_q  <= mem_re;
      rd_owner_q <= (state_q == StGrant);
      if (wk_rvld) begin
        wk_rdata_q <= bus.mem_rdata;
      end
      if (cfg_rvld) begin
        cfg_rdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vm_port_arbiter.sv
// Directed bench for vm_port_arbiter with a behavioural single-port Vm SRAM.
module tb_vm_port_arbiter;

  localparam int unsigned NNW        = 12;
  localparam int unsigned VW         = 20;
  localparam int unsigned STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vm_port_arbiter_if #(.NNW(NNW), .VW(VW)) bus ();

  vm_port_arbiter #(
    .NNW        (NNW),
    .VW         (VW),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [VW-1:0]  mem [0:(1<<NNW)-1];
  logic           pl_we = 1'b0;
  logic [NNW-1:0] pl_addr = '0;
  logic [VW-1:0]  pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  int excl_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_re && bus.mem_we) excl_err <= excl_err + 1;
      if (bus.wk_rvld && bus.cfg_rvld) excl_err <= excl_err + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wk_re = 1'b0;  bus.wk_we = 1'b0;  bus.wk_addr = '0;  bus.wk_wdata = '0;
    bus.cfg_re = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
  endtask

  task automatic preload(input logic [NNW-1:0] a, input logic [VW-1:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    next_cyc();
    pl_we = 1'b0;
  endtask

  int cnt;

  initial begin
    idle_inputs();
    preload(12'h005, 20'h12345);
    preload(12'h001, 20'h0BEEF);
    preload(12'h002, 20'h54321);
    preload(12'h031, 20'h33333);
    preload(12'h020, 20'h00777);

    // Reset state
    sample();
    check_eq("rst cfg_busy",  32'(bus.cfg_busy),  32'd0);
    check_eq("rst wk_rvld",   32'(bus.wk_rvld),   32'd0);
    check_eq("rst cfg_rvld",  32'(bus.cfg_rvld),  32'd0);
    check_eq("rst wk_rdata",  32'(bus.wk_rdata),  32'd0);
    check_eq("rst cfg_rdata", 32'(bus.cfg_rdata), 32'd0);
    check_eq("rst mem_re",    32'(bus.mem_re),    32'd0);
    check_eq("rst mem_we",    32'(bus.mem_we),    32'd0);
    check_eq("rst wk_ready",  32'(bus.wk_ready),  32'd1);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    // Config read on an idle bus
    bus.cfg_re = 1'b1; bus.cfg_addr = 12'h005;
    sample();
    check_eq("c0 busy", 32'(bus.cfg_busy), 32'd0);
    check_eq("c0 mem_re", 32'(bus.mem_re), 32'd0);
    next_cyc();
    bus.cfg_re = 1'b0;
    sample();
    check_eq("c1 busy", 32'(bus.cfg_busy), 32'd1);
    check_eq("c1 mem_re", 32'(bus.mem_re), 32'd0);
    next_cyc();
    sample();
    check_eq("c2 mem_re", 32'(bus.mem_re), 32'd1);
    check_eq("c2 mem_addr", 32'(bus.mem_addr), 32'h005);
    check_eq("c2 wk_ready", 32'(bus.wk_ready), 32'd0);
    next_cyc();
    sample();
    check_eq("c3 cfg_rvld", 32'(bus.cfg_rvld), 32'd1);
    check_eq("c3 cfg_rdata", 32'(bus.cfg_rdata), 32'h12345);
    check_eq("c3 busy", 32'(bus.cfg_busy), 32'd0);
    check_eq("c3 wk_rvld", 32'(bus.wk_rvld), 32'd0);
    next_cyc();
    sample();
    check_eq("c4 cfg_rvld", 32'(bus.cfg_rvld), 32'd0);
    check_eq("c4 cfg_rdata hold", 32'(bus.cfg_rdata), 32'h12345);
    next_cyc();

    // Starvation: continuous work reads plus a config write
    bus.wk_re = 1'b1; bus.wk_addr = 12'h020;
    bus.cfg_we = 1'b1; bus.cfg_addr = 12'h010; bus.cfg_wdata = 20'h00AAA;
    sample();
    check_eq("s0 wk_ready", 32'(bus.wk_ready), 32'd1);
    check_eq("s0 mem_re", 32'(bus.mem_re), 32'd1);
    check_eq("s0 mem_addr", 32'(bus.mem_addr), 32'h020);
    next_cyc();
    bus.cfg_we = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      sample();
      if (bus.wk_ready && bus.mem_re && !bus.mem_we && bus.mem_addr == 12'h020) cnt++;
      next_cyc();
    end
    check_eq("s work ops in pend", 32'(cnt), 32'd8);
    sample();
    check_eq("s9 wk_ready", 32'(bus.wk_ready), 32'd0);
    check_eq("s9 mem_we", 32'(bus.mem_we), 32'd1);
    check_eq("s9 mem_re", 32'(bus.mem_re), 32'd0);
    check_eq("s9 mem_addr", 32'(bus.mem_addr), 32'h010);
    check_eq("s9 mem_wdata", 32'(bus.mem_wdata), 32'h00AAA);
    next_cyc();
    sample();
    check_eq("s10 wk_ready", 32'(bus.wk_ready), 32'd1);
    check_eq("s10 busy", 32'(bus.cfg_busy), 32'd0);
    next_cyc();
    idle_inputs();
    next_cyc();
    next_cyc();

    // Work read at 0x001 returning just before a granted config read at 0x002
    bus.wk_re = 1'b1; bus.wk_addr = 12'h001;
    bus.cfg_re = 1'b1; bus.cfg_addr = 12'h002;
    next_cyc();
    bus.cfg_re = 1'b0;
    repeat (8) next_cyc();
    sample();
    check_eq("b9 wk_ready", 32'(bus.wk_ready), 32'd0);
    check_eq("b9 mem_re", 32'(bus.mem_re), 32'd1);
    check_eq("b9 mem_addr", 32'(bus.mem_addr), 32'h002);
    check_eq("b9 wk_rvld", 32'(bus.wk_rvld), 32'd1);
    check_eq("b9 wk_rdata", 32'(bus.wk_rdata), 32'h0BEEF);
    check_eq("b9 cfg_rvld", 32'(bus.cfg_rvld), 32'd0);
    next_cyc();
    sample();
    check_eq("b10 cfg_rvld", 32'(bus.cfg_rvld), 32'd1);
    check_eq("b10 cfg_rdata", 32'(bus.cfg_rdata), 32'h54321);
    check_eq("b10 wk_rvld", 32'(bus.wk_rvld), 32'd0);
    check_eq("b10 mem_addr", 32'(bus.mem_addr), 32'h001);
    next_cyc();
    idle_inputs();
    sample();
    check_eq("b11 wk_rvld", 32'(bus.wk_rvld), 32'd1);
    check_eq("b11 cfg_rvld", 32'(bus.cfg_rvld), 32'd0);
    check_eq("b11 cfg_rdata hold", 32'(bus.cfg_rdata), 32'h54321);
    next_cyc();
    next_cyc();

    // Second config pulse while busy is ignored
    bus.cfg_we = 1'b1; bus.cfg_addr = 12'h030; bus.cfg_wdata = 20'h11111;
    next_cyc();
    bus.cfg_we = 1'b1; bus.cfg_addr = 12'h031; bus.cfg_wdata = 20'h22222;
    sample();
    check_eq("i1 busy", 32'(bus.cfg_busy), 32'd1);
    check_eq("i1 mem_we", 32'(bus.mem_we), 32'd0);
    next_cyc();
    idle_inputs();
    sample();
    check_eq("i2 mem_we", 32'(bus.mem_we), 32'd1);
    check_eq("i2 mem_addr", 32'(bus.mem_addr), 32'h030);
    check_eq("i2 mem_wdata", 32'(bus.mem_wdata), 32'h11111);
    next_cyc();
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      sample();
      cnt += int'(bus.mem_re) + int'(bus.mem_we) + int'(bus.cfg_busy);
      next_cyc();
    end
    check_eq("i extra ops", 32'(cnt), 32'd0);

    // Reset while PEND discards the slot
    bus.wk_re = 1'b1; bus.wk_addr = 12'h020;
    bus.cfg_re = 1'b1; bus.cfg_addr = 12'h005;
    next_cyc();
    bus.cfg_re = 1'b0;
    sample();
    check_eq("r1 busy", 32'(bus.cfg_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("r async busy", 32'(bus.cfg_busy), 32'd0);
    check_eq("r async wk_rvld", 32'(bus.wk_rvld), 32'd0);
    idle_inputs();
    next_cyc();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      sample();
      cnt += int'(bus.mem_re) + int'(bus.mem_we) + int'(bus.cfg_rvld) + int'(bus.cfg_busy);
      next_cyc();
    end
    check_eq("r post ops", 32'(cnt), 32'd0);

    // Simultaneous work write (re+we) and config write in IDLE
    bus.wk_re = 1'b1; bus.wk_we = 1'b1; bus.wk_addr = 12'h041; bus.wk_wdata = 20'h0F00D;
    bus.cfg_we = 1'b1; bus.cfg_addr = 12'h040; bus.cfg_wdata = 20'h0CAFE;
    sample();
    check_eq("w0 mem_we", 32'(bus.mem_we), 32'd1);
    check_eq("w0 mem_re", 32'(bus.mem_re), 32'd0);
    check_eq("w0 mem_addr", 32'(bus.mem_addr), 32'h041);
    check_eq("w0 mem_wdata", 32'(bus.mem_wdata), 32'h0F00D);
    next_cyc();
    idle_inputs();
    sample();
    check_eq("w1 mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("w1 busy", 32'(bus.cfg_busy), 32'd1);
    next_cyc();
    sample();
    check_eq("w2 mem_we", 32'(bus.mem_we), 32'd1);
    check_eq("w2 mem_addr", 32'(bus.mem_addr), 32'h040);
    check_eq("w2 mem_wdata", 32'(bus.mem_wdata), 32'h0CAFE);
    next_cyc();
    next_cyc();

    check_eq("mem 0x010", 32'(mem[12'h010]), 32'h00AAA);
    check_eq("mem 0x030", 32'(mem[12'h030]), 32'h11111);
    check_eq("mem 0x031", 32'(mem[12'h031]), 32'h33333);
    check_eq("mem 0x040", 32'(mem[12'h040]), 32'h0CAFE);
    check_eq("mem 0x041", 32'(mem[12'h041]), 32'h0F00D);
    check_eq("exclusive", 32'(excl_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vm_port_arbiter.md
VM_PORT_ARBITER -- requirements
Module: vm_port_arbiter

Interface
REQ-001 Parameter NNW, default 12, neuron/Vm address width.
REQ-002 Parameter VW, default 20, Vm data width.
REQ-003 Parameter STARVE_MAX, default 8, maximum cycles a config request waits behind work traffic.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously.
REQ-006 wk_re, wk_we  input  1 each  work-pipeline read/write request; both high is illegal, treated as write.
REQ-007 wk_addr  input  NNW  work address; wk_wdata  input  VW  work write data.
REQ-008 wk_ready  output  1  work request accepted this cycle.
REQ-009 wk_rvld  output  1  work read data valid; wk_rdata  output  VW.
REQ-010 cfg_re, cfg_we  input  1 each  configurator single-cycle request pulse, captured into the pending slot.
REQ-011 cfg_addr  input  NNW; cfg_wdata  input  VW.
REQ-012 cfg_busy  output  1  pending slot occupied; new cfg pulses are ignored while high.
REQ-013 cfg_rvld  output  1  config read data valid; cfg_rdata  output  VW.
REQ-014 mem_re, mem_we  output  1 each; mem_addr  output  NNW; mem_wdata  output  VW  single-port Vm SRAM.
REQ-015 mem_rdata  input  VW  SRAM read data, valid exactly 1 cycle after mem_re.

Function
REQ-016 Pending slot: a cfg_re or cfg_we pulse while cfg_busy=0 registers op, address and data and sets cfg_busy the next cycle.
REQ-017 States: IDLE (slot empty), PEND (slot full, waiting), GRANT (slot issued to memory this cycle).
REQ-018 IDLE->PEND on a captured cfg pulse; PEND->GRANT when wk_re=wk_we=0 or starve count = STARVE_MAX; GRANT->IDLE unconditionally.
REQ-019 In IDLE and PEND, wk_ready = 1 combinationally; a work request drives mem_* in the same cycle with zero added latency.
REQ-020 In GRANT, wk_ready = 0 and mem_* carry the pending config op; the work requester holds its request.
REQ-021 Starve counter: cleared on entry to PEND, increments each PEND cycle with a work request present, saturates at STARVE_MAX.
REQ-022 The memory sees at most one op per cycle; mem_re and mem_we are never both high.
REQ-023 Read return: a 1-bit owner tag registered with mem_re; the next cycle asserts wk_rvld or cfg_rvld (exactly one) for 1 cycle with rdata = mem_rdata.
REQ-024 wk_rdata and cfg_rdata hold their last valid value while the matching rvld is low.
REQ-025 cfg_busy falls on the cycle after GRANT for writes; for reads it falls together with cfg_rvld, so a new cfg pulse is accepted no earlier than that cycle.
REQ-026 A cfg pulse arriving in the same cycle as a work request in IDLE is captured; work is served that cycle.
REQ-027 When no request is active, mem_re = mem_we = 0 and mem_addr/mem_wdata are don't-care.

Reset
REQ-028 On rst_n=0: state IDLE, cfg_busy 0, starve count 0, owner tag 0, wk_rvld 0, cfg_rvld 0, wk_rdata 0, cfg_rdata 0; mem_re/mem_we 0.
REQ-029 A reset in PEND or GRANT discards the pending config op; no rvld is produced for it after reset.

Verification
REQ-030 Idle bus; cfg_re addr 0x005 with mem holding 0x12345 -> mem_re 1 cycle after capture, cfg_rvld 1 cycle later, cfg_rdata 0x12345, cfg_busy low the same cycle.
REQ-031 Continuous wk_re stream plus cfg_we addr 0x010 data 0x00AAA -> 8 work ops pass, GRANT on the 9th PEND cycle with wk_ready 0 for 1 cycle; mem location 0x010 = 0x00AAA.
REQ-032 Work read at 0x001 immediately followed by GRANT cfg read at 0x002 -> wk_rvld, then cfg_rvld on consecutive cycles with the correct data each, never both high.
REQ-033 Second cfg pulse while cfg_busy=1 -> ignored, no extra memory op, slot contents unchanged.
REQ-034 rst_n asserted during PEND -> cfg_busy 0 asynchronously; after release there is no mem op and no cfg_rvld for the discarded request.
REQ-035 Simultaneous cfg_we and wk_we in IDLE -> work write issued that cycle, config write issued the next cycle when work is idle; both locations are correct.
